// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES of latency,
// then a byte/halfword/word access on a word-organised RAM.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a request; req_ready high
// S_WAIT   | latency padding; down-counter runs to zero
// S_ACCESS | single cycle: legality check, RAM read/write, result capture
// S_RESP   | rsp_valid held with stable data until rsp_ready
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic        busy
);

   localparam int          IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_U = DEPTH_WORDS;
   localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t       state, state_nxt;
   logic [31:0]  addr_q;
   logic         we_q;
   logic [2:0]   funct3_q;
   logic [31:0]  wdata_q;
   logic [3:0]   cnt_q;
   logic         accept;

   logic [31:0]  mem [DEPTH_WORDS];

   logic [IW-1:0] idx;
   logic          acc_err;
   logic [31:0]   rd_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_val;
   logic [3:0]    byte_en;
   logic [31:0]   lane_data;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
         S_WAIT:   if (cnt_q == 4'd0) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state
   always_comb begin
      req_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      rsp_valid = (state == S_RESP);
      accept    = req_valid && (state == S_IDLE);
   end

   // Access datapath: legality, load extraction and store lane steering
   always_comb begin
      idx = addr_q[IW+1:2];
      acc_err = 1'b0;
      if (!(funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) acc_err = 1'b1;
      if (we_q && funct3_q[2]) acc_err = 1'b1;
      if (funct3_q[1:0] == 2'b01 && addr_q[0]) acc_err = 1'b1;
      if (funct3_q == 3'b010 && addr_q[1:0] != 2'b00) acc_err = 1'b1;
      if ({2'b00, addr_q[31:2]} >= DEPTH_U) acc_err = 1'b1;

      rd_word = acc_err ? 32'd0 : mem[idx];
      case (addr_q[1:0])
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

      case (funct3_q)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b010:  load_val = rd_word;
         3'b100:  load_val = {24'd0, byte_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = 32'd0;
      endcase

      case (funct3_q[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
         end
         default: begin
            byte_en   = 4'b1111;
            lane_data = wdata_q;
         end
      endcase
   end

   // Request capture and wait-state down-counter
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else if (accept) begin
         addr_q   <= req_addr;
         we_q     <= req_we;
         funct3_q <= req_funct3;
         wdata_q  <= req_wdata;
         cnt_q    <= CNT_INIT;
      end else if (state == S_WAIT && cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Response registers, captured in the access cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_rdata <= 32'd0;
         rsp_error <= 1'b0;
      end else if (state == S_ACCESS) begin
         rsp_error <= acc_err;
         rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_val;
      end
   end

   // RAM write; contents survive reset, but reset suppresses an in-flight store
   always_ff @(posedge clk) begin
      if (!reset && state == S_ACCESS && we_q && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

endmodule
